// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   pc_state_t            : sequencer FSM states (BOOT / RUN / HOLD)
//   STEP_FULL, STEP_HALF  : PC increments for 32-bit and 16-bit instructions
//   DEFAULT_*_VECTOR      : default reset and trap addresses
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } pc_state_t;

  localparam int unsigned STEP_FULL = 4;
  localparam int unsigned STEP_HALF = 2;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_step_adder.sv
// Sequential-address adder: sum = base + 2 (half_step) or base + 4,
// wrapping modulo 2^XLEN.
// Ports:
//   base      in  XLEN  current PC
//   half_step in  1     add 2 instead of 4
//   sum       out XLEN  next sequential PC
module pc_step_adder
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] base,
  input  logic            half_step,
  output logic [XLEN-1:0] sum
);

  assign sum = base + (half_step ? XLEN'(STEP_HALF) : XLEN'(STEP_FULL));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage. Holds the PC, steps it
// by 4 (or 2 for compressed instructions when ENABLE_C), and applies
// trap, branch and pending redirects with fixed priority.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   stall          hazard unit holds the PC
//   fetchReady     instruction memory accepts the current PC
//   isCompressed   current instruction is 16-bit (ignored unless ENABLE_C)
//   branchTaken    redirect request, branchTarget valid with it
//   trap           trap request
//   pc, pcValid    current fetch address and its valid flag
//   pcNextSeq      pc + step, combinational link value
//   misaligned     one-cycle pulse when a misaligned target was rejected
//
// state | meaning
// BOOT  | first cycle after reset, pc not yet valid
// RUN   | normal fetch, pc advances or takes redirects
// HOLD  | redirect latched in pending register, waiting for an advance
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter bit              ENABLE_C     = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetchReady,
  input  logic            isCompressed,
  input  logic            branchTaken,
  input  logic [XLEN-1:0] branchTarget,
  input  logic            trap,
  output logic [XLEN-1:0] pc,
  output logic            pcValid,
  output logic [XLEN-1:0] pcNextSeq,
  output logic            misaligned
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pending_q, pending_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] seq_pc;
  logic            half_step;
  logic            advance;
  logic            target_misaligned;

  assign half_step = ENABLE_C && isCompressed;

  pc_step_adder #(.XLEN(XLEN)) u_step_adder (
    .base      (pc_q),
    .half_step (half_step),
    .sum       (seq_pc)
  );

  assign pcValid = (state_q != ST_BOOT);
  assign advance = pcValid && fetchReady && !stall;

  // Without compressed support targets must be word aligned.
  assign target_misaligned = branchTarget[0] || (!ENABLE_C && branchTarget[1]);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    mis_d     = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // Branches cannot originate before the first fetch; traps can.
        state_d = ST_RUN;
        if (trap) pc_d = TRAP_VECTOR;
      end
      default: begin
        if (trap) begin
          pc_d      = TRAP_VECTOR;
          pending_d = '0;
          state_d   = ST_RUN;
        end else if (branchTaken && target_misaligned) begin
          pc_d      = TRAP_VECTOR;
          pending_d = '0;
          mis_d     = 1'b1;
          state_d   = ST_RUN;
        end else if (branchTaken) begin
          // Newest redirect wins, even over one already pending.
          if (advance) begin
            pc_d    = branchTarget;
            state_d = ST_RUN;
          end else begin
            pending_d = branchTarget;
            state_d   = ST_HOLD;
          end
        end else if (state_q == ST_HOLD) begin
          if (advance) begin
            pc_d    = pending_q;
            state_d = ST_RUN;
          end
        end else if (advance) begin
          pc_d = seq_pc;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_VECTOR;
      pending_q <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      mis_q     <= mis_d;
    end
  end

  assign pc         = pc_q;
  assign pcNextSeq  = seq_pc;
  assign misaligned = mis_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer replacing the fixed +4 PC adder in the RISC-V datapath fetch stage. Holds the architectural PC, advances by 4 (or 2 for compressed instructions when enabled), and applies branch/jump redirects and trap redirects with fixed priority. A fetch handshake and a pending-redirect register keep redirects from being lost while fetch is stalled or instruction memory is busy.

## Interface
Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect (XLEN bits).
- ENABLE_C, 0, 1 = compressed instructions allowed (2-byte alignment, +2 step).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit holds PC.
- fetchReady  in  1  instruction memory accepts the current PC.
- isCompressed  in  1  fetched instruction is 16-bit; ignored when ENABLE_C=0.
- branchTaken  in  1  single-cycle redirect request from execute.
- branchTarget  in  XLEN  redirect target, valid with branchTaken.
- trap  in  1  single-cycle trap request.
- pc  out  XLEN  current fetch address.
- pcValid  out  1  pc is valid for fetch.
- pcNextSeq  out  XLEN  pc + step, combinational (link value for jal/jalr).
- misaligned  out  1  one-cycle pulse: rejected misaligned branch target.

## Operation
- States: BOOT, RUN, HOLD.
- advance = pcValid && fetchReady && !stall.
- step = 2 if ENABLE_C && isCompressed, else 4; addition modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
- Misaligned target: branchTarget[0]=1, or branchTarget[1]=1 with ENABLE_C=0.
- Priority per cycle: reset > trap > misaligned branch > branch > pending redirect > sequential > hold.
- reset: pc=RESET_VECTOR, pcValid=0, misaligned=0, pending cleared, state BOOT.
- BOOT: unconditionally -> RUN next cycle, pcValid=1, pc unchanged.
- trap (RUN or HOLD): pc=TRAP_VECTOR next cycle regardless of stall/fetchReady; pending cleared; -> RUN.
- Misaligned branchTaken: treated as trap (pc=TRAP_VECTOR), misaligned=1 for one cycle; target never loaded.
- Aligned branchTaken in RUN: if advance, pc=branchTarget next cycle; else latch target into pending register, -> HOLD.
- HOLD: pc held; on first advance cycle pc=pending target, -> RUN. A new aligned branchTaken in HOLD overwrites pending (newest wins); if advance in that same cycle, new target loaded directly.
- RUN, no redirect: advance -> pc=pc+step; else pc held.
- trap/branch in BOOT: trap honoured; branchTaken ignored.

## Timing
- All state updates on rising clock; no combinational path from inputs to pc/pcValid/misaligned.
- pcNextSeq combinational from pc and isCompressed.
- Reset values: pc=RESET_VECTOR, pcValid=0, misaligned=0.
- First valid PC one cycle after reset deasserts.
- Redirect latency: 1 cycle when advance; else 1 cycle after first advance cycle.
- Trap latency: exactly 1 cycle, unaffected by stall.
- Reset asserted mid-HOLD discards pending target.

## Structure
- Shared package pc_pkg: state enum (BOOT/RUN/HOLD), step constants 2/4, default vectors.
- One sub-module natural: pc_step_adder (pc + step, width XLEN), reused for pcNextSeq and sequential update.
- Pending register (XLEN bits) and FSM in top module.

## Test plan
- Reset, RESET_VECTOR=0x1000 -> pc=0x1000, pcValid=0 one cycle then 1; with fetchReady=1, pc 0x1004, 0x1008.
- ENABLE_C=1, isCompressed alternating 1/0 from 0x0 -> pc 0x2, 0x6, 0x8.
- branchTaken target 0x40 while stall=1 for 3 cycles -> pc held, state HOLD; first cycle stall=0 -> pc=0x40 next cycle.
- branchTaken 0x40 then 0x80 during stall, then trap -> pc=TRAP_VECTOR, pending discarded, subsequent pc TRAP_VECTOR+4.
- ENABLE_C=0, branchTarget=0x42 -> misaligned pulse 1 cycle, pc=TRAP_VECTOR; 0x41 with ENABLE_C=1 same.
- pc=0xFFFF_FFFC, advance -> pc=0x0; reset asserted in HOLD -> pc=RESET_VECTOR, pending target never applied.
